// File: rtl/sram_dp_be.sv
// Simple-dual-port synchronous SRAM with per-byte write enables, selectable
// read-during-write behaviour, optional output register and a clear sequencer.
module sram_dp_be #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned RDW_MODE = 0,
  parameter int unsigned OUT_REG  = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  output logic                  init_busy,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [DATA_W/8-1:0]   wr_be,
  input  logic                  rd_en,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  rd_valid
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned NB    = DATA_W / 8;

  typedef enum logic {
    ST_INIT,
    ST_READY
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   init_cnt_q, init_cnt_d;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                accept;
  logic                wr_fire;
  logic                rd_fire;
  logic                collide;
  logic [DATA_W-1:0]   old_word;
  logic [DATA_W-1:0]   merged_word;
  logic [DATA_W-1:0]   rd_word;
  logic                out_fire;
  logic [DATA_W-1:0]   out_word;
  logic [DATA_W-1:0]   rd_data_q;
  logic                rd_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    case (state_q)
      ST_INIT: begin
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == ADDR_W'(DEPTH - 1)) begin
          state_d = ST_READY;
        end
      end
      ST_READY: begin
        if (clr) begin
          state_d    = ST_INIT;
          init_cnt_d = '0;
        end
      end
      default: begin
        state_d    = ST_INIT;
        init_cnt_d = '0;
      end
    endcase
  end

  assign init_busy = (state_q == ST_INIT);

  // clr wins over any access presented in the same cycle
  assign accept  = (state_q == ST_READY) && !clr;
  assign wr_fire = accept && wr_en;
  assign rd_fire = accept && rd_en;

  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) begin
      mem[init_cnt_q] <= '0;
    end else if (wr_fire) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (wr_be[i]) begin
          mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end

  assign old_word = mem[rd_addr];
  assign collide  = wr_fire && (wr_addr == rd_addr);

  always_comb begin
    merged_word = old_word;
    for (int unsigned i = 0; i < NB; i++) begin
      if (wr_be[i]) begin
        merged_word[8*i +: 8] = wr_data[8*i +: 8];
      end
    end
  end

  assign rd_word = ((RDW_MODE == 1) && collide) ? merged_word : old_word;

  // Stage 1 runs regardless of FSM state so an in-flight read still lands
  generate
    if (OUT_REG != 0) begin : g_oreg
      logic              s1_valid;
      logic [DATA_W-1:0] s1_data;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s1_valid <= 1'b0;
          s1_data  <= '0;
        end else begin
          s1_valid <= rd_fire;
          if (rd_fire) begin
            s1_data <= rd_word;
          end
        end
      end

      assign out_fire = s1_valid;
      assign out_word = s1_data;
    end else begin : g_noreg
      assign out_fire = rd_fire;
      assign out_word = rd_word;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= out_fire;
      if (out_fire) begin
        rd_data_q <= out_word;
      end
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_sram_dp_be.sv
// Directed bench for sram_dp_be: four instances (8/32-bit, both collision
// modes, with and without output register) driven by shared stimulus.
module tb_sram_dp_be;

  logic        clk;
  logic        rst_n;
  logic        clr;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic        rd_en;
  logic [3:0]  rd_addr;

  logic        busy_a, busy_b, busy_w, busy_c;
  logic        valid_a, valid_b, valid_w, valid_c;
  logic [7:0]  data_a, data_c;
  logic [31:0] data_b, data_w;

  int n_checks;
  int n_fail;

  // a: 8-bit read-first, b: 32-bit write-first, w: 32-bit read-first,
  // c: 8-bit read-first with output register
  sram_dp_be #(.DATA_W(8), .ADDR_W(4), .RDW_MODE(0), .OUT_REG(0)) u_a (
    .clk(clk), .rst_n(rst_n), .clr(clr), .init_busy(busy_a),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data[7:0]), .wr_be(wr_be[0:0]),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(data_a), .rd_valid(valid_a));

  sram_dp_be #(.DATA_W(32), .ADDR_W(4), .RDW_MODE(1), .OUT_REG(0)) u_b (
    .clk(clk), .rst_n(rst_n), .clr(clr), .init_busy(busy_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(data_b), .rd_valid(valid_b));

  sram_dp_be #(.DATA_W(32), .ADDR_W(4), .RDW_MODE(0), .OUT_REG(0)) u_w (
    .clk(clk), .rst_n(rst_n), .clr(clr), .init_busy(busy_w),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(data_w), .rd_valid(valid_w));

  sram_dp_be #(.DATA_W(8), .ADDR_W(4), .RDW_MODE(0), .OUT_REG(1)) u_c (
    .clk(clk), .rst_n(rst_n), .clr(clr), .init_busy(busy_c),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data[7:0]), .wr_be(wr_be[0:0]),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(data_c), .rd_valid(valid_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [3:0]  wa;
    logic [31:0] wd;
    logic [3:0]  be;
    logic        re;
    logic [3:0]  ra;
    logic        ev;
    logic [7:0]  ea;
    logic [31:0] eb;
    logic [31:0] ew;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [3:0] wa, input logic [31:0] wd,
                       input logic [3:0] be, input logic re, input logic [3:0] ra,
                       input logic c);
    wr_en   = we;
    wr_addr = wa;
    wr_data = wd;
    wr_be   = be;
    rd_en   = re;
    rd_addr = ra;
    clr     = c;
  endtask

  task automatic idle();
    drive(1'b0, 4'h0, 32'h0, 4'h0, 1'b0, 4'h0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counts cycles while init_busy stays high; also counts stray rd_valid pulses
  task automatic wait_init(output int n, output int stray);
    n = 0;
    stray = 0;
    while (busy_a && n < 100) begin
      step();
      n++;
      if (valid_a || valid_b || valid_w || valid_c) stray++;
    end
  endtask

  task automatic read_all_zero(input string tag);
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 4'h0, 32'h0, 4'h0, 1'b1, 4'(i), 1'b0);
      step();
      check($sformatf("%s_valid_a[%0d]", tag, i), {31'h0, valid_a}, 32'h1);
      check($sformatf("%s_data_a[%0d]", tag, i), {24'h0, data_a}, 32'h0);
      check($sformatf("%s_data_w[%0d]", tag, i), data_w, 32'h0);
      if (i > 0) begin
        check($sformatf("%s_valid_c[%0d]", tag, i), {31'h0, valid_c}, 32'h1);
        check($sformatf("%s_data_c[%0d]", tag, i), {24'h0, data_c}, 32'h0);
      end
    end
    idle();
  endtask

  initial begin
    int n;
    int stray;
    n_checks = 0;
    n_fail   = 0;

    //          we  wa     wd            be    re  ra     ev  ea     eb            ew
    vecs[0]  = '{1, 4'd3,  32'h000000A5, 4'h1, 0, 4'd0,  0, 8'h00, 32'h00000000, 32'h00000000};
    vecs[1]  = '{0, 4'd0,  32'h00000000, 4'h0, 1, 4'd3,  1, 8'hA5, 32'h000000A5, 32'h000000A5};
    vecs[2]  = '{0, 4'd0,  32'h00000000, 4'h0, 0, 4'd0,  0, 8'hA5, 32'h000000A5, 32'h000000A5};
    vecs[3]  = '{1, 4'd5,  32'h11223344, 4'hF, 0, 4'd0,  0, 8'hA5, 32'h000000A5, 32'h000000A5};
    vecs[4]  = '{1, 4'd5,  32'hAABBCCDD, 4'h5, 0, 4'd0,  0, 8'hA5, 32'h000000A5, 32'h000000A5};
    vecs[5]  = '{0, 4'd0,  32'h00000000, 4'h0, 1, 4'd5,  1, 8'hDD, 32'h11BB33DD, 32'h11BB33DD};
    vecs[6]  = '{1, 4'd7,  32'h00000010, 4'hF, 0, 4'd0,  0, 8'hDD, 32'h11BB33DD, 32'h11BB33DD};
    vecs[7]  = '{1, 4'd7,  32'h00000020, 4'hF, 1, 4'd7,  1, 8'h10, 32'h00000020, 32'h00000010};
    vecs[8]  = '{0, 4'd0,  32'h00000000, 4'h0, 1, 4'd7,  1, 8'h20, 32'h00000020, 32'h00000020};
    vecs[9]  = '{1, 4'd5,  32'h99887766, 4'h2, 1, 4'd5,  1, 8'hDD, 32'h11BB77DD, 32'h11BB33DD};
    vecs[10] = '{0, 4'd0,  32'h00000000, 4'h0, 1, 4'd5,  1, 8'hDD, 32'h11BB77DD, 32'h11BB77DD};
    vecs[11] = '{1, 4'd9,  32'h0000005A, 4'hF, 1, 4'd3,  1, 8'hA5, 32'h000000A5, 32'h000000A5};
    vecs[12] = '{0, 4'd0,  32'h00000000, 4'h0, 1, 4'd9,  1, 8'h5A, 32'h0000005A, 32'h0000005A};
    vecs[13] = '{1, 4'd3,  32'hFFFFFFFF, 4'h0, 0, 4'd0,  0, 8'h5A, 32'h0000005A, 32'h0000005A};
    vecs[14] = '{0, 4'd0,  32'h00000000, 4'h0, 1, 4'd3,  1, 8'hA5, 32'h000000A5, 32'h000000A5};
    vecs[15] = '{1, 4'd15, 32'hC3C3C3C3, 4'hF, 1, 4'd15, 1, 8'h00, 32'hC3C3C3C3, 32'h00000000};
    vecs[16] = '{0, 4'd0,  32'h00000000, 4'h0, 1, 4'd15, 1, 8'hC3, 32'hC3C3C3C3, 32'hC3C3C3C3};

    // Reset state
    rst_n = 1'b0;
    idle();
    #2;
    check("rst_busy_a", {31'h0, busy_a}, 32'h1);
    check("rst_valid_a", {31'h0, valid_a}, 32'h0);
    check("rst_data_w", data_w, 32'h0);
    check("rst_valid_c", {31'h0, valid_c}, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_init(n, stray);
    check("init_len", n, 16);
    check("init_busy_c", {31'h0, busy_c}, 32'h0);
    check("init_busy_w", {31'h0, busy_w}, 32'h0);
    read_all_zero("pwr");
    step();

    // Table-driven single-cycle vectors (latency-1 instances)
    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].be, vecs[i].re, vecs[i].ra, 1'b0);
      step();
      check($sformatf("v%0d_valid_a", i), {31'h0, valid_a}, {31'h0, vecs[i].ev});
      check($sformatf("v%0d_valid_b", i), {31'h0, valid_b}, {31'h0, vecs[i].ev});
      check($sformatf("v%0d_data_a", i), {24'h0, data_a}, {24'h0, vecs[i].ea});
      check($sformatf("v%0d_data_b", i), data_b, vecs[i].eb);
      check($sformatf("v%0d_data_w", i), data_w, vecs[i].ew);
    end
    idle();
    step();

    // Output register: back-to-back reads of 1,2,3
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 4'(i), 32'(i + 1), 4'hF, 1'b0, 4'h0, 1'b0);
      step();
    end
    idle();
    step();
    drive(1'b0, 4'h0, 32'h0, 4'h0, 1'b1, 4'd0, 1'b0);
    step();
    check("oreg_n1_valid_c", {31'h0, valid_c}, 32'h0);
    check("oreg_n1_data_a", {23'h0, valid_a, data_a}, 32'h101);
    drive(1'b0, 4'h0, 32'h0, 4'h0, 1'b1, 4'd1, 1'b0);
    step();
    check("oreg_n2", {23'h0, valid_c, data_c}, 32'h101);
    drive(1'b0, 4'h0, 32'h0, 4'h0, 1'b1, 4'd2, 1'b0);
    step();
    check("oreg_n3", {23'h0, valid_c, data_c}, 32'h102);
    idle();
    step();
    check("oreg_n4", {23'h0, valid_c, data_c}, 32'h103);
    step();
    check("oreg_n5_hold", {23'h0, valid_c, data_c}, 32'h003);

    // clr with concurrent write; in-flight OUT_REG read must still complete
    drive(1'b0, 4'h0, 32'h0, 4'h0, 1'b1, 4'd1, 1'b0);
    step();
    check("clr_pre_a", {23'h0, valid_a, data_a}, 32'h102);
    drive(1'b1, 4'd2, 32'hEEEEEEEE, 4'hF, 1'b1, 4'd1, 1'b1);
    step();
    check("clr_busy", {31'h0, busy_a}, 32'h1);
    check("clr_rd_dropped_a", {31'h0, valid_a}, 32'h0);
    check("clr_inflight_c", {23'h0, valid_c, data_c}, 32'h102);
    drive(1'b1, 4'd0, 32'h77777777, 4'hF, 1'b1, 4'd0, 1'b0);
    wait_init(n, stray);
    check("clr_len", n, 16);
    check("clr_stray_valid", stray, 0);
    idle();
    read_all_zero("clr");
    step();

    // Reset asserted mid-sweep restarts the sweep
    drive(1'b1, 4'd4, 32'h44444444, 4'hF, 1'b0, 4'h0, 1'b0);
    step();
    drive(1'b0, 4'h0, 32'h0, 4'h0, 1'b1, 4'd4, 1'b0);
    step();
    check("mid_pre_w", data_w, 32'h44444444);
    drive(1'b0, 4'h0, 32'h0, 4'h0, 1'b0, 4'h0, 1'b1);
    step();
    idle();
    repeat (8) step();
    rst_n = 1'b0;
    #2;
    check("mid_rst_busy", {31'h0, busy_a}, 32'h1);
    check("mid_rst_data_w", data_w, 32'h0);
    check("mid_rst_data_c", {24'h0, data_c}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_init(n, stray);
    check("mid_rst_len", n, 16);
    read_all_zero("rst2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
